// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } fill_state_e;

    localparam logic [4:0] SEQ_DET_DEF_PAT = 5'b01101;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter; built only when SEQDET_COUNT_EN is defined.
module seq_det_match_cnt
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Parametrised serial pattern detector with overlap control and loadable pattern.
// Optional saturating match counter and match_cnt port under SEQDET_COUNT_EN.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_DET_DEF_PAT),
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             overlap_en,
    input  logic             clear,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_data,
    output logic             match
`ifdef SEQDET_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int unsigned      FCNT_W   = $clog2(PAT_W + 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(PAT_W);

    logic [PAT_W-1:0]  hist_d,  hist_q;
    logic [FCNT_W-1:0] fcnt_d,  fcnt_q;
    logic [PAT_W-1:0]  pat_d,   pat_q;
    logic              match_d, match_q;

    fill_state_e       state_c;
    logic [PAT_W-1:0]  hist_shift_c;
    logic [FCNT_W-1:0] fcnt_inc_c;
    logic              hit_c;

    assign state_c = (fcnt_q == FCNT_MAX) ? ARMED : FILL;

    // Priority: clear, then pat_load, then the valid beat; bubbles hold everything.
    always_comb begin
        hist_d       = hist_q;
        fcnt_d       = fcnt_q;
        pat_d        = pat_q;
        hit_c        = 1'b0;
        hist_shift_c = {hist_q[PAT_W-2:0], in_bit};
        fcnt_inc_c   = (state_c == ARMED) ? fcnt_q : fcnt_q + FCNT_W'(1);

        if (clear) begin
            hist_d = '0;
            fcnt_d = '0;
            if (pat_load) begin
                pat_d = pat_data;
            end
        end else if (pat_load) begin
            pat_d  = pat_data;
            fcnt_d = '0;
        end else if (in_valid) begin
            hist_d = hist_shift_c;
            fcnt_d = fcnt_inc_c;
            if ((fcnt_inc_c == FCNT_MAX) && (hist_shift_c == pat_q)) begin
                hit_c = 1'b1;
                if (!overlap_en) begin
                    fcnt_d = '0;
                end
            end
        end
        match_d = hit_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= '0;
            fcnt_q  <= '0;
            pat_q   <= PATTERN;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fcnt_q  <= fcnt_d;
            pat_q   <= pat_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

`ifdef SEQDET_COUNT_EN
    seq_det_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit_c),
        .clr (clear),
        .cnt (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench: directed vector table, hand-written reset sequences, random vs. reference model.
module tb_seq_pattern_detector;

    localparam int unsigned PAT_W = 5;
    localparam logic [4:0]  DEF_PAT = 5'b01101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       overlap_en = 1'b0;
    logic       clear = 1'b0;
    logic       pat_load = 1'b0;
    logic [4:0] pat_data = '0;
    logic       match;
`ifdef SEQDET_COUNT_EN
    logic [7:0] match_cnt;
    logic       match2;
    logic [1:0] match_cnt2;
`endif

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(5), .PATTERN(DEF_PAT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .overlap_en(overlap_en), .clear(clear), .pat_load(pat_load),
        .pat_data(pat_data), .match(match)
`ifdef SEQDET_COUNT_EN
        , .match_cnt(match_cnt)
`endif
    );

`ifdef SEQDET_COUNT_EN
    seq_pattern_detector #(.PAT_W(5), .PATTERN(DEF_PAT), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .overlap_en(overlap_en), .clear(clear), .pat_load(pat_load),
        .pat_data(pat_data), .match(match2), .match_cnt(match_cnt2)
    );
`endif

    typedef struct packed {
        logic       v;
        logic       b;
        logic       ov;
        logic       cl;
        logic       pl;
        logic [4:0] pd;
        logic       e;
    } vec_t;

    vec_t tab[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: bits received since the last discard, pattern, hit count.
    bit         win[$];
    logic [4:0] m_pat;
    int         m_cnt;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic void model_reset();
        win.delete();
        m_pat = DEF_PAT;
        m_cnt = 0;
    endfunction

    function automatic bit model_step(input logic v, b, ov, cl, pl, input logic [4:0] pd);
        int val;
        if (cl) begin
            win.delete();
            m_cnt = 0;
            if (pl) m_pat = pd;
            return 1'b0;
        end
        if (pl) begin
            m_pat = pd;
            win.delete();
            return 1'b0;
        end
        if (!v) return 1'b0;
        win.push_back(b);
        if (win.size() > PAT_W) void'(win.pop_front());
        if (win.size() < PAT_W) return 1'b0;
        val = 0;
        foreach (win[i]) val = (val << 1) | int'(win[i]);
        if (val != int'(m_pat)) return 1'b0;
        m_cnt++;
        if (!ov) win.delete();
        return 1'b1;
    endfunction

    task automatic step(input logic v, b, ov, cl, pl, input logic [4:0] pd,
                        input bit use_tab, input logic tab_e, input string nm);
        bit me;
        in_valid = v; in_bit = b; overlap_en = ov; clear = cl; pat_load = pl; pat_data = pd;
        me = model_step(v, b, ov, cl, pl, pd);
        @(posedge clk); #1;
        check(nm, int'(match), use_tab ? int'(tab_e) : int'(me));
`ifdef SEQDET_COUNT_EN
        check({nm, "_cnt"}, int'(match_cnt), (m_cnt > 255) ? 255 : m_cnt);
        check({nm, "_cnt2"}, int'(match_cnt2), (m_cnt > 3) ? 3 : m_cnt);
        check({nm, "_m2"}, int'(match2), int'(match));
`endif
    endtask

    function automatic void add(input logic v, b, ov, cl, pl, input logic [4:0] pd, input logic e);
        vec_t t;
        t.v = v; t.b = b; t.ov = ov; t.cl = cl; t.pl = pl; t.pd = pd; t.e = e;
        tab.push_back(t);
    endfunction

    function automatic void add_bits(input logic [15:0] bits, input int n, input logic ov,
                                     input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) add(1'b1, bits[i], ov, 1'b0, 1'b0, 5'd0, exp[i]);
    endfunction

    initial begin
        logic [4:0] basic;
        basic = 5'b01101;

        // Basic, overlap and non-overlap runs on the reset pattern.
        add_bits(16'b01101, 5, 1'b1, 16'b00001);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        add_bits(16'b01101101, 8, 1'b1, 16'b00001001);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        add_bits(16'b01101101, 8, 1'b0, 16'b00001000);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        // Bubbles between every beat never break the partial match.
        for (int i = 4; i >= 0; i--) begin
            add(1'b1, basic[i], 1'b0, 1'b0, 1'b0, 5'd0, (i == 0) ? 1'b1 : 1'b0);
            for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        end
        // Pattern load with a dropped beat, then nine 1s in overlap mode.
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'b11111, 1'b0);
        add_bits(16'b111111111, 9, 1'b1, 16'b000011111);
        // Reloading restarts the fill count even though history already matches.
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11111, 1'b0);
        add_bits(16'b11111, 5, 1'b1, 16'b00001);
        // Non-overlap spacing of PAT_W beats.
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 1'b0);
        add_bits(16'b1111111111, 10, 1'b0, 16'b0000100001);
        // clear + pat_load together; the beat would have hit the old pattern.
        add_bits(16'b1111, 4, 1'b1, 16'b0000);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'b01101, 1'b0);
        add_bits(16'b01101, 5, 1'b1, 16'b00001);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_match", int'(match), 0);
`ifdef SEQDET_COUNT_EN
        check("reset_cnt", int'(match_cnt), 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tab[i])
            step(tab[i].v, tab[i].b, tab[i].ov, tab[i].cl, tab[i].pl, tab[i].pd,
                 1'b1, tab[i].e, $sformatf("vec%0d", i));

        // Async reset mid-stream discards the partial match.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, "pre_rst_clr");
        for (int i = 4; i >= 1; i--)
            step(1'b1, basic[i], 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "pre_rst");
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "post_rst_beat");

        // Reset asserted during a match pulse drops it immediately.
        for (int i = 4; i >= 0; i--)
            step(1'b1, basic[i], 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, (i == 0) ? 1'b1 : 1'b0, "pulse_seq");
        rst = 1'b1;
        #1;
        check("async_rst_match", int'(match), 0);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Random stream against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic rv, rb, rcl, rpl;
            logic [4:0] rpd;
            rv  = ($urandom_range(0, 3) != 0);
            rb  = 1'($urandom);
            rcl = ($urandom_range(0, 99) < 2);
            rpl = ($urandom_range(0, 99) < 2);
            rpd = 5'($urandom);
            if (($urandom_range(0, 49)) == 0) overlap_en = ~overlap_en;
            step(rv, rb, overlap_en, rcl, rpl, rpd, 1'b0, 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial bit-pattern detector, the successor to the fixed 5-bit Mealy detectors in the lab sequence-detector set. It matches a PAT_W-bit pattern against a gated serial bit stream, supports overlapping and non-overlapping detection, and accepts a runtime-loadable pattern. It sits between a serial front end (`in_valid`/`in_bit`) and a status/interrupt consumer. The one-cycle `match` pulse is registered.

## Interface
- PAT_W, 5, pattern length in bits; legal range ≥ 2
- PATTERN, 5'b01101, reset-time pattern; MSB is the first bit received
- CNT_W, 8, width of the match counter
- clk  input  1  clock; all logic uses the rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  `in_bit` is a valid beat this cycle
- in_bit  input  1  serial data bit
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
- clear  input  1  synchronous clear of history, match and counter
- pat_load  input  1  load `pat_data` into the pattern register
- pat_data  input  PAT_W  new pattern; MSB is the first bit received
- match  output  1  one-cycle pulse, registered
- match_cnt  output  CNT_W  saturating match count; present only with SEQDET_COUNT_EN

## Operation
- Registers:
  - `hist[PAT_W-1:0]`: shift history. The newest bit is at the LSB.
  - `fcnt`: fill count, range 0..PAT_W, saturating.
  - `pat[PAT_W-1:0]`: active pattern.
- FSM states, derived from `fcnt`:
  - FILL when `fcnt < PAT_W`.
  - ARMED when `fcnt == PAT_W`.
- On a valid beat, where `in_valid=1` and neither `clear` nor `pat_load` is high:
  - `hist_n = {hist[PAT_W-2:0], in_bit}`.
  - `fcnt_n = min(fcnt+1, PAT_W)`.
  - `hit = (fcnt_n == PAT_W) && (hist_n == pat)`.
- On a hit:
  - `match <= 1`.
  - If `overlap_en=0`, `fcnt <= 0`, which returns the FSM to FILL and discards the history.
  - If `overlap_en=1`, `fcnt` stays at PAT_W.
- Any cycle without a hit: `match <= 0`.
- Cycles with `in_valid=0` are bubbles. History and `fcnt` are held, so bubbles never break a partial match.
- Priority, highest first: `rst`, then `clear`, then `pat_load`, then the valid beat.
  - `clear`: `fcnt<=0`, `hist<=0`, `match<=0`, counter cleared. The beat in that cycle is dropped. If `pat_load` is also high, `pat` is loaded as well.
  - `pat_load`: `pat<=pat_data`, `fcnt<=0`, `match<=0`. The beat in that cycle is dropped.
- `overlap_en` is sampled in the same cycle as the completing beat.
- Reset values:
  - `hist=0`, `fcnt=0` (FILL), `pat=PATTERN`.
  - `match=0`, `match_cnt=0`.
- Reset mid-stream discards all partial history.

## Timing
- Latency: `match` rises on the clock edge that samples the completing beat and is visible for exactly one cycle.
- Back-to-back matches are possible in overlap mode with a period of one beat (for example pattern all-ones).
- Non-overlap mode: the minimum spacing between matches is PAT_W valid beats.
- `match_cnt` updates on the same edge as `match`.
- The pattern register takes effect for the first beat after the `pat_load` cycle.

## Configuration
- `SEQDET_COUNT_EN` defined:
  - The `match_cnt` port and its counter are built.
  - The counter increments on each hit and saturates at 2^CNT_W−1.
  - `clear` and `rst` zero it.
- `SEQDET_COUNT_EN` not defined:
  - No counter logic and no `match_cnt` port.
  - All other behaviour is identical.

## Structure
- Package `seq_det_pkg`:
  - Fill-state enum (FILL, ARMED).
  - Default-pattern constant `SEQ_DET_DEF_PAT = 5'b01101`.
  - Function `sat_inc` (saturating increment).
- Sub-module `seq_det_match_cnt`: the saturating counter (CNT_W parameter; inputs `inc` and `clr`). It is instantiated only under `SEQDET_COUNT_EN`.

## Test plan
- **Basic detection:** default pattern, beats 0,1,1,0,1 → `match` = 1 for one cycle after the 5th edge; `match_cnt` = 1.
- **Overlap mode:** beats 0,1,1,0,1,1,0,1 with `overlap_en=1` → two pulses, after beats 5 and 8.
  - Same stream with `overlap_en=0` → a single pulse after beat 5.
- **Bubbles and reset:**
  - 0,1,1,0,1 with 3 idle cycles (`in_valid=0`) after each beat → one pulse after the last beat.
  - 0,1,1,0, then async `rst`, then 1 → no pulse.
- **Pattern load:** `pat_load` with `pat_data=5'b11111` (a beat driven in the same cycle is dropped), then six 1s with `overlap_en=1` → pulses after beats 5 and 6.
- **Counter saturation and clear:** CNT_W=2, overlap mode, pattern 11111, nine 1s → five hits and `match_cnt` saturates at 3; then `clear` → `match_cnt` = 0 and `match` = 0.
- **Priority:** `clear` and `pat_load` both high in one cycle → pattern loaded, history and counter cleared, beat ignored.
